// File: rtl/ct_ifu_icache_data_array_param.sv
// Parametrised IFU I-cache data array: BANKS single-port banks over 2^IDX_W lines,
// a one-entry refill write buffer drained around reads, RAW forwarding and optional parity.
module ct_ifu_icache_data_array_param #(
    parameter int BANKS      = 4,
    parameter int BANK_DW    = 32,
    parameter int IDX_W      = 10,
    parameter int PARITY_EN  = 0,
    parameter int STARVE_MAX = 7
) (
    input  logic                     forever_cpuclk,
    input  logic                     cpurst,
    input  logic                     rd_req_vld,
    output logic                     rd_req_rdy,
    input  logic [IDX_W-1:0]         rd_req_idx,
    input  logic [BANKS-1:0]         rd_req_bank_en,
    output logic                     rd_rsp_vld,
    output logic [BANKS*BANK_DW-1:0] rd_rsp_data,
    output logic [BANKS-1:0]         rd_rsp_par_err,
    input  logic                     wr_req_vld,
    output logic                     wr_req_rdy,
    input  logic [IDX_W-1:0]         wr_req_idx,
    input  logic [BANKS*BANK_DW-1:0] wr_req_data,
    input  logic [BANKS-1:0]         wr_req_bank_en,
    output logic                     wr_buf_pending
);
    localparam int         DW         = BANKS * BANK_DW;
    localparam int         SW         = BANK_DW + ((PARITY_EN != 0) ? 1 : 0);
    localparam int         DEPTH      = 1 << IDX_W;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic             buf_vld_reg;
    logic [IDX_W-1:0] buf_idx_reg;
    logic [DW-1:0]    buf_data_reg;
    logic [BANKS-1:0] buf_bank_en_reg;
    logic [7:0]       starve_cnt_reg;
    logic [7:0]       starve_cnt_next;

    logic             rd_rsp_vld_reg;
    logic [DW-1:0]    rd_rsp_data_reg;
    logic [BANKS-1:0] rd_rsp_par_err_reg;
    logic [DW-1:0]    rd_data_next;
    logic [BANKS-1:0] rd_err_next;

    logic conflict;
    logic force_drain;
    logic drain;
    logic rd_fire;
    logic wr_fire;
    logic idx_hit;

    // Reads own the banks unless the buffered write has waited STARVE_MAX cycles.
    assign conflict    = rd_req_vld & (|(rd_req_bank_en & buf_bank_en_reg));
    assign force_drain = buf_vld_reg & (starve_cnt_reg == STARVE_LIM);
    assign drain       = buf_vld_reg & (~conflict | force_drain);
    assign rd_req_rdy  = ~(force_drain & conflict);
    assign rd_fire     = rd_req_vld & rd_req_rdy;
    assign wr_req_rdy  = ~buf_vld_reg;
    assign wr_fire     = wr_req_vld & ~buf_vld_reg;
    assign idx_hit     = buf_vld_reg & ~drain & (buf_idx_reg == rd_req_idx);

    assign wr_buf_pending = buf_vld_reg;
    assign rd_rsp_vld     = rd_rsp_vld_reg;
    assign rd_rsp_data    = rd_rsp_data_reg;
    assign rd_rsp_par_err = rd_rsp_par_err_reg;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!buf_vld_reg || drain) begin
            starve_cnt_next = 8'd0;
        end else if (starve_cnt_reg != STARVE_LIM) begin
            starve_cnt_next = starve_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            buf_vld_reg     <= 1'b0;
            buf_idx_reg     <= '0;
            buf_data_reg    <= '0;
            buf_bank_en_reg <= '0;
            starve_cnt_reg  <= 8'd0;
        end else begin
            if (wr_fire) begin
                buf_vld_reg     <= 1'b1;
                buf_idx_reg     <= wr_req_idx;
                buf_data_reg    <= wr_req_data;
                buf_bank_en_reg <= wr_req_bank_en;
            end else if (drain) begin
                buf_vld_reg <= 1'b0;
            end
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Bank gi lives in the gi-th most significant slot of every per-bank vector.
    generate
        for (genvar gi = 0; gi < BANKS; gi++) begin : gen_bank
            localparam int BI  = BANKS - 1 - gi;
            localparam int LSB = BI * BANK_DW;

            logic [SW-1:0] mem_reg [DEPTH];
            logic [SW-1:0] wr_word;
            logic [SW-1:0] rd_word;
            logic          rd_perr;
            logic          fwd;

            if (PARITY_EN != 0) begin : gen_par
                assign wr_word = {^buf_data_reg[LSB +: BANK_DW], buf_data_reg[LSB +: BANK_DW]};
                assign rd_perr = rd_word[SW-1] ^ (^rd_word[BANK_DW-1:0]);
            end else begin : gen_nopar
                assign wr_word = buf_data_reg[LSB +: BANK_DW];
                assign rd_perr = 1'b0;
            end

            always_ff @(posedge forever_cpuclk) begin
                if (drain && buf_bank_en_reg[BI]) begin
                    mem_reg[buf_idx_reg] <= wr_word;
                end
            end

            assign rd_word = mem_reg[rd_req_idx];
            assign fwd     = idx_hit & buf_bank_en_reg[BI];

            assign rd_data_next[LSB +: BANK_DW] = !rd_req_bank_en[BI] ? '0 :
                                                  fwd ? buf_data_reg[LSB +: BANK_DW] :
                                                  rd_word[BANK_DW-1:0];
            assign rd_err_next[BI] = rd_req_bank_en[BI] & ~fwd & rd_perr;
        end
    endgenerate

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rd_rsp_vld_reg     <= 1'b0;
            rd_rsp_data_reg    <= '0;
            rd_rsp_par_err_reg <= '0;
        end else begin
            rd_rsp_vld_reg <= rd_fire;
            if (rd_fire) begin
                rd_rsp_data_reg    <= rd_data_next;
                rd_rsp_par_err_reg <= rd_err_next;
            end
        end
    end

endmodule

// File: doc/ct_ifu_icache_data_array_param.md
# ct_ifu_icache_data_array_param

Parametrised I-cache data array for the IFU. It replaces the fixed four-bank, 32-bit, single-depth data array with `BANKS` banks of `BANK_DW` bits over 2^`IDX_W` lines. It adds a one-entry refill write buffer with read-priority arbitration, read-after-write forwarding, a starvation guard, and optional per-bank parity. It sits between the IFU fetch/refill control and the cache storage, with one-cycle registered read data.

## Interface
Parameters:
- `BANKS`, 4, number of independent banks.
- `BANK_DW`, 32, data bits per bank.
- `IDX_W`, 10, line index width; depth per bank is 2^`IDX_W`.
- `PARITY_EN`, 0, 1 stores and checks one even-parity bit per bank word.
- `STARVE_MAX`, 7, maximum wait cycles for the buffered write before a forced drain; legal range 1..255.

Ports:
- `forever_cpuclk` in 1: single clock; all state on its rising edge.
- `cpurst` in 1: asynchronous, active-high reset.
- `rd_req_vld` in 1: read request.
- `rd_req_rdy` out 1: read accepted when `rd_req_vld & rd_req_rdy`.
- `rd_req_idx` in `IDX_W`: read line index.
- `rd_req_bank_en` in `BANKS`: banks to read.
- `rd_rsp_vld` out 1: read data valid.
- `rd_rsp_data` out `BANKS*BANK_DW`: bank 0 is in the MSBs.
- `rd_rsp_par_err` out `BANKS`: per-bank parity error, qualified by `rd_rsp_vld`.
- `wr_req_vld` in 1: refill write request.
- `wr_req_rdy` out 1: equal to `~buf_vld`.
- `wr_req_idx` in `IDX_W`: write line index.
- `wr_req_data` in `BANKS*BANK_DW`: write data, same bank ordering as read data.
- `wr_req_bank_en` in `BANKS`: banks to write.
- `wr_buf_pending` out 1: equal to `buf_vld`.

## Operation
- **Storage.** Each bank is a single-port array of `BANK_DW` bits (plus 1 parity bit if `PARITY_EN`). Array contents are not reset.
- **Write accept.** When `wr_req_vld & wr_req_rdy`, idx/data/bank_en are latched into the buffer and `buf_vld` is set. A write never goes to the array in its accept cycle.
- **Conflict.** `conflict = rd_req_vld & |(rd_req_bank_en & buf_bank_en)`.
- **Force.** `force = buf_vld & (starve_cnt == STARVE_MAX)`.
- **Drain.** When `buf_vld & (~conflict | force)`, the enabled banks of the buffer are written to the array and `buf_vld` clears at the next edge.
- **Read ready.** `rd_req_rdy = ~(force & conflict)`. Reads win over the buffer except on a forced drain.
- **Read issue.** An accepted read reads its enabled banks at the edge.
  - If `buf_vld`, the buffer is not draining, `buf_idx == rd_req_idx`, and the bank is enabled in both read and buffer: that bank's data is forwarded from the buffer, and its parity error is forced to 0.
  - Banks not enabled in `rd_req_bank_en` return 0 with no error.
- **Parity.** When `PARITY_EN`, the stored bit is the XOR of the written word. Read error = stored bit != XOR of the read word. When `PARITY_EN=0`, `rd_rsp_par_err` is always 0.
- **Starvation counter** (`starve_cnt`, 8 bits):
  - cleared when `buf_vld` is 0 or a drain occurs;
  - otherwise increments by 1 per cycle the buffer is valid and blocked;
  - saturates at `STARVE_MAX`.
- **Write accept vs. read, same cycle, same index.** The read returns pre-write array data. Forwarding applies only to writes already held in the buffer.
- **Reset mid-operation.** A buffered write is discarded. An in-flight read response is dropped.

## Timing
- **Read latency.** Accept in cycle N gives `rd_rsp_vld=1` with data/error in cycle N+1. Outputs are registered. `rd_rsp_vld` is high for one cycle per accepted read. Back-to-back reads sustain 1 per cycle.
- **Response hold.** `rd_rsp_data` and `rd_rsp_par_err` hold their last value when `rd_rsp_vld=0`.
- **Write throughput.** Accept in cycle N gives a drain no earlier than edge N+1, and `wr_req_rdy` high again at N+2 at best. Peak rate is 1 write per 2 cycles.
- **Worst-case blocking.** A buffered write waits at most `STARVE_MAX` cycles of conflict. It then drains in the forced cycle while the conflicting read is stalled (`rd_req_rdy=0` for that one cycle).
- **Reset values.**
  - `rd_rsp_vld=0`, `rd_rsp_data=0`, `rd_rsp_par_err=0`.
  - `buf_vld=0`, so `wr_req_rdy=1` and `wr_buf_pending=0`.
  - `starve_cnt=0`, so `rd_req_rdy=1`.

## Test plan
- **Basic write/read.** Reset; write idx 5, data {A0000000,B1111111,C2222222,D3333333}, all banks; idle 1 cycle; read idx 5, all banks -> `rd_rsp_vld` one cycle later with the same data, `par_err=0`.
- **Conflict then forced drain.** `STARVE_MAX=3`; write idx 9 bank0; continuous bank0 reads to idx 1 -> buffer blocked 3 cycles, then `rd_req_rdy=0` for exactly 1 cycle, drain occurs, `wr_buf_pending` falls the next cycle.
- **Forwarding.** Buffer holds idx 7 bank2 = 12345678 under a blocking read stream; read idx 7, banks 2+3 -> bank2 returns 12345678 (forwarded), bank3 returns old array data.
- **Disjoint banks.** Buffer bank1 write while reading banks 0,2,3 every cycle -> drain in the first cycle, no read stall, `wr_req_rdy` high 2 cycles after accept.
- **Parity.** `PARITY_EN=1`; write bank0 = 00000001; corrupt the stored parity via backdoor; read -> `rd_rsp_par_err=4'b1000`, other banks 0.
- **Reset mid-operation.** Assert `cpurst` with buffer valid and a read in flight -> `wr_buf_pending=0` and `rd_rsp_vld=0` immediately; the array location is unchanged on a later read.
